// File: rtl/sparc_pkg.sv
// Shared definitions for the SPARC-style PC/nPC sequencer: FSM encoding,
// address width, default reset vector and increment, alignment helpers.
package sparc_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam logic [ADDR_W-1:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] DEF_INC = 32'd4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

    function automatic logic misaligned(input logic [ADDR_W-1:0] a);
        return |a[1:0];
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC/nPC selection: trap > halt > stall > jmpl > branch >
// sequential, with target alignment and trap-capture enable.
module pc_next_sel
    import sparc_pkg::*;
#(
    parameter logic [ADDR_W-1:0] INC = DEF_INC
) (
    input  state_e              state,
    input  logic [ADDR_W-1:0]   pc,
    input  logic [ADDR_W-1:0]   npc,
    input  logic                stall,
    input  logic                br_taken,
    input  logic [ADDR_W-1:0]   br_target,
    input  logic                jmpl_valid,
    input  logic [ADDR_W-1:0]   jmpl_target,
    input  logic                trap_req,
    input  logic [ADDR_W-1:0]   trap_vector,
    input  logic                halt_req,
    output logic [ADDR_W-1:0]   next_pc,
    output logic [ADDR_W-1:0]   next_npc,
    output logic                pc_ld,
    output logic                capture_en,
    output logic                advance,
    output logic                align_err_next
);

    logic [ADDR_W-1:0] tgt_s;
    logic              ctrl_state_s;

    // Priority selection of the values PC/nPC take at the next edge
    always_comb begin
        next_pc        = pc;
        next_npc       = npc;
        capture_en     = 1'b0;
        advance        = 1'b0;
        align_err_next = 1'b0;
        tgt_s          = '0;
        case (state)
            ST_RUN, ST_HALT: begin
                if (trap_req) begin
                    tgt_s          = align_addr(trap_vector);
                    next_pc        = tgt_s;
                    next_npc       = tgt_s + INC;
                    capture_en     = 1'b1;
                    align_err_next = misaligned(trap_vector);
                end else if ((state == ST_RUN) && !halt_req && !stall) begin
                    // Delay slot: PC always steps to nPC, only nPC is redirected
                    advance = 1'b1;
                    next_pc = npc;
                    if (jmpl_valid) begin
                        tgt_s          = align_addr(jmpl_target);
                        next_npc       = tgt_s;
                        align_err_next = misaligned(jmpl_target);
                    end else if (br_taken) begin
                        tgt_s          = align_addr(br_target);
                        next_npc       = tgt_s;
                        align_err_next = misaligned(br_target);
                    end else begin
                        next_npc = npc + INC;
                    end
                end else begin
                    next_pc  = pc;
                    next_npc = npc;
                end
            end
            default: begin
                next_pc  = pc;
                next_npc = npc;
            end
        endcase
    end

    assign ctrl_state_s = (state == ST_RUN) || (state == ST_HALT);
    assign pc_ld        = ctrl_state_s && (next_pc != pc);

endmodule

// File: rtl/pc_sequencer.sv
// PC/nPC sequencer: owns the pc/npc/epc/enpc registers and the
// BOOT/RUN/TRAP/HALT control FSM; next-address choice lives in pc_next_sel.
module pc_sequencer
    import sparc_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [ADDR_W-1:0] INC          = DEF_INC
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                br_taken,
    input  logic [ADDR_W-1:0]   br_target,
    input  logic                jmpl_valid,
    input  logic [ADDR_W-1:0]   jmpl_target,
    input  logic                annul_slot,
    input  logic                trap_req,
    input  logic [ADDR_W-1:0]   trap_vector,
    input  logic                halt_req,
    output logic [ADDR_W-1:0]   pc_out,
    output logic [ADDR_W-1:0]   npc_out,
    output logic                pc_ld,
    output logic [ADDR_W-1:0]   next_pc,
    output logic                fetch_valid,
    output logic [ADDR_W-1:0]   epc_out,
    output logic [ADDR_W-1:0]   enpc_out,
    output logic                align_err,
    output logic [1:0]          state_out
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] npc_q, npc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [ADDR_W-1:0] enpc_q, enpc_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              align_err_q, align_err_d;

    logic [ADDR_W-1:0] next_pc_s;
    logic [ADDR_W-1:0] next_npc_s;
    logic              pc_ld_s;
    logic              capture_en_s;
    logic              advance_s;
    logic              align_err_next_s;

    pc_next_sel #(
        .INC(INC)
    ) u_sel (
        .state          (state_q),
        .pc             (pc_q),
        .npc            (npc_q),
        .stall          (stall),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .jmpl_valid     (jmpl_valid),
        .jmpl_target    (jmpl_target),
        .trap_req       (trap_req),
        .trap_vector    (trap_vector),
        .halt_req       (halt_req),
        .next_pc        (next_pc_s),
        .next_npc       (next_npc_s),
        .pc_ld          (pc_ld_s),
        .capture_en     (capture_en_s),
        .advance        (advance_s),
        .align_err_next (align_err_next_s)
    );

    // FSM transitions and fetch_valid / trap-capture next values
    always_comb begin
        state_d       = state_q;
        fetch_valid_d = fetch_valid_q;
        pc_d          = next_pc_s;
        npc_d         = next_npc_s;
        align_err_d   = align_err_next_s;
        if (capture_en_s) begin
            epc_d  = pc_q;
            enpc_d = npc_q;
        end else begin
            epc_d  = epc_q;
            enpc_d = enpc_q;
        end
        case (state_q)
            ST_BOOT: begin
                state_d       = ST_RUN;
                fetch_valid_d = 1'b1;
            end
            ST_RUN: begin
                if (capture_en_s) begin
                    state_d       = ST_TRAP;
                    fetch_valid_d = 1'b0;
                end else if (halt_req) begin
                    state_d       = ST_HALT;
                    fetch_valid_d = 1'b0;
                end else if (advance_s) begin
                    state_d       = ST_RUN;
                    fetch_valid_d = ~annul_slot;
                end else begin
                    state_d       = ST_RUN;
                    fetch_valid_d = fetch_valid_q;
                end
            end
            ST_TRAP: begin
                state_d       = ST_RUN;
                fetch_valid_d = 1'b1;
            end
            ST_HALT: begin
                if (capture_en_s) begin
                    state_d = ST_TRAP;
                end else begin
                    state_d = ST_HALT;
                end
                fetch_valid_d = 1'b0;
            end
            default: begin
                state_d       = ST_BOOT;
                fetch_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_VECTOR;
            npc_q         <= RESET_VECTOR + INC;
            epc_q         <= '0;
            enpc_q        <= '0;
            fetch_valid_q <= 1'b0;
            align_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            npc_q         <= npc_d;
            epc_q         <= epc_d;
            enpc_q        <= enpc_d;
            fetch_valid_q <= fetch_valid_d;
            align_err_q   <= align_err_d;
        end
    end

    assign pc_out      = pc_q;
    assign npc_out     = npc_q;
    assign epc_out     = epc_q;
    assign enpc_out    = enpc_q;
    assign fetch_valid = fetch_valid_q;
    assign align_err   = align_err_q;
    assign state_out   = state_q;
    assign pc_ld       = pc_ld_s;
    assign next_pc     = next_pc_s;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the driver pushes the hand-computed
// per-cycle expectation, a negedge monitor pops and compares.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, br_taken, jmpl_valid, annul_slot, trap_req, halt_req;
    logic [31:0] br_target, jmpl_target, trap_vector;
    logic [31:0] pc_out, npc_out, next_pc, epc_out, enpc_out;
    logic        pc_ld, fetch_valid, align_err;
    logic [1:0]  state_out;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic        ld;
        logic [31:0] nxt;
        logic        fv;
        logic [1:0]  st;
        logic        ae;
        logic [31:0] epc;
        logic [31:0] enpc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] e_epc = 32'd0;
    logic [31:0] e_enpc = 32'd0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jmpl_valid  (jmpl_valid),
        .jmpl_target (jmpl_target),
        .annul_slot  (annul_slot),
        .trap_req    (trap_req),
        .trap_vector (trap_vector),
        .halt_req    (halt_req),
        .pc_out      (pc_out),
        .npc_out     (npc_out),
        .pc_ld       (pc_ld),
        .next_pc     (next_pc),
        .fetch_valid (fetch_valid),
        .epc_out     (epc_out),
        .enpc_out    (enpc_out),
        .align_err   (align_err),
        .state_out   (state_out)
    );

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        stall = 1'b0; br_taken = 1'b0; jmpl_valid = 1'b0; annul_slot = 1'b0;
        trap_req = 1'b0; halt_req = 1'b0;
        br_target = 32'd0; jmpl_target = 32'd0; trap_vector = 32'd0;
    endtask

    task automatic expect_cyc(input logic [31:0] p, input logic [31:0] np, input logic ld,
                              input logic [31:0] nx, input logic fv, input logic [1:0] st,
                              input logic ae);
        exp_t e;
        e.pc = p; e.npc = np; e.ld = ld; e.nxt = nx; e.fv = fv; e.st = st; e.ae = ae;
        e.epc = e_epc; e.enpc = e_enpc;
        sb_q.push_back(e);
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            cmp("pc",        pc_out,               e.pc);
            cmp("npc",       npc_out,              e.npc);
            cmp("pc_ld",     {31'd0, pc_ld},       {31'd0, e.ld});
            cmp("next_pc",   next_pc,              e.nxt);
            cmp("fetch_vld", {31'd0, fetch_valid}, {31'd0, e.fv});
            cmp("state",     {30'd0, state_out},   {30'd0, e.st});
            cmp("align_err", {31'd0, align_err},   {31'd0, e.ae});
            cmp("epc",       epc_out,              e.epc);
            cmp("enpc",      enpc_out,             e.enpc);
        end
    end

    initial begin
        clr();
        reset = 1'b1;
        tick();
        expect_cyc(32'h0, 32'h4, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0);
        tick(); reset = 1'b0;
        expect_cyc(32'h0, 32'h4, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0);
        // free run
        tick(); expect_cyc(32'h0, 32'h4, 1'b1, 32'h4, 1'b1, 2'd1, 1'b0);
        tick(); expect_cyc(32'h4, 32'h8, 1'b1, 32'h8, 1'b1, 2'd1, 1'b0);
        // branch at pc=8
        tick(); br_taken = 1'b1; br_target = 32'h100;
        expect_cyc(32'h8, 32'hC, 1'b1, 32'hC, 1'b1, 2'd1, 1'b0);
        tick(); clr(); expect_cyc(32'hC, 32'h100, 1'b1, 32'h100, 1'b1, 2'd1, 1'b0);
        // annulled branch
        tick(); br_taken = 1'b1; br_target = 32'h180; annul_slot = 1'b1;
        expect_cyc(32'h100, 32'h104, 1'b1, 32'h104, 1'b1, 2'd1, 1'b0);
        tick(); clr(); expect_cyc(32'h104, 32'h180, 1'b1, 32'h180, 1'b0, 2'd1, 1'b0);
        tick(); br_taken = 1'b1; br_target = 32'h20;
        expect_cyc(32'h180, 32'h184, 1'b1, 32'h184, 1'b1, 2'd1, 1'b0);
        tick(); clr(); expect_cyc(32'h184, 32'h20, 1'b1, 32'h20, 1'b1, 2'd1, 1'b0);
        // trap under stall at pc=0x20
        tick(); trap_req = 1'b1; stall = 1'b1; trap_vector = 32'h800;
        expect_cyc(32'h20, 32'h24, 1'b1, 32'h800, 1'b1, 2'd1, 1'b0);
        tick(); stall = 1'b0; e_epc = 32'h20; e_enpc = 32'h24;
        expect_cyc(32'h800, 32'h804, 1'b0, 32'h800, 1'b0, 2'd2, 1'b0);
        // jmpl beats br, misaligned target
        tick(); clr(); jmpl_valid = 1'b1; jmpl_target = 32'h203; br_taken = 1'b1; br_target = 32'h300;
        expect_cyc(32'h800, 32'h804, 1'b1, 32'h804, 1'b1, 2'd1, 1'b0);
        tick(); clr(); expect_cyc(32'h804, 32'h200, 1'b1, 32'h200, 1'b1, 2'd1, 1'b1);
        tick(); br_taken = 1'b1; br_target = 32'h40;
        expect_cyc(32'h200, 32'h204, 1'b1, 32'h204, 1'b1, 2'd1, 1'b0);
        tick(); clr(); expect_cyc(32'h204, 32'h40, 1'b1, 32'h40, 1'b1, 2'd1, 1'b0);
        // halt at pc=0x40
        tick(); halt_req = 1'b1;
        expect_cyc(32'h40, 32'h44, 1'b0, 32'h40, 1'b1, 2'd1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(); clr(); br_taken = 1'b1; br_target = 32'h500;
            expect_cyc(32'h40, 32'h44, 1'b0, 32'h40, 1'b0, 2'd3, 1'b0);
        end
        // trap out of HALT, misaligned vector
        tick(); clr(); trap_req = 1'b1; trap_vector = 32'h902;
        expect_cyc(32'h40, 32'h44, 1'b1, 32'h900, 1'b0, 2'd3, 1'b0);
        tick(); clr(); e_epc = 32'h40; e_enpc = 32'h44;
        expect_cyc(32'h900, 32'h904, 1'b0, 32'h900, 1'b0, 2'd2, 1'b1);
        tick(); halt_req = 1'b1;
        expect_cyc(32'h900, 32'h904, 1'b0, 32'h900, 1'b1, 2'd1, 1'b0);
        tick(); clr(); expect_cyc(32'h900, 32'h904, 1'b0, 32'h900, 1'b0, 2'd3, 1'b0);
        // asynchronous reset in HALT, checked before any clock edge
        tick(); reset = 1'b1;
        #1;
        cmp("async_pc",    pc_out,             32'h0);
        cmp("async_state", {30'd0, state_out}, 32'd0);
        cmp("async_epc",   epc_out,            32'h0);
        e_epc = 32'h0; e_enpc = 32'h0;
        expect_cyc(32'h0, 32'h4, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0);
        tick(); reset = 1'b0;
        expect_cyc(32'h0, 32'h4, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0);
        // stall in RUN holds everything
        tick(); stall = 1'b1; annul_slot = 1'b1;
        expect_cyc(32'h0, 32'h4, 1'b0, 32'h0, 1'b1, 2'd1, 1'b0);
        // wrap through 0xFFFFFFFC
        tick(); clr(); br_taken = 1'b1; br_target = 32'hFFFF_FFF8;
        expect_cyc(32'h0, 32'h4, 1'b1, 32'h4, 1'b1, 2'd1, 1'b0);
        tick(); clr(); expect_cyc(32'h4, 32'hFFFF_FFF8, 1'b1, 32'hFFFF_FFF8, 1'b1, 2'd1, 1'b0);
        tick(); expect_cyc(32'hFFFF_FFF8, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b1, 2'd1, 1'b0);
        tick(); expect_cyc(32'hFFFF_FFFC, 32'h0, 1'b1, 32'h0, 1'b1, 2'd1, 1'b0);
        tick(); expect_cyc(32'h0, 32'h4, 1'b1, 32'h4, 1'b1, 2'd1, 1'b0);
        @(negedge clk);
        #1;
        cmp("sb_drain", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
